// File: rtl/context_switch_scheduler.sv
// Context-switch sequencer: arbitrates the global stage bus and steps the context RAMs through write, settle and read.
// Optional switch statistics (stats_clear, stored_count, local_count) are built only when CONTEXT_SWITCH_STATS_EN is defined.
//
// state  | meaning
// IDLE   | forward upstream_stage, ready for a switch request
// WRITE  | broadcast STAGE_WRITE_TO_MEM for one cycle
// SETTLE | broadcast STAGE_IDLE while the settle down-counter runs
// READ   | broadcast STAGE_READ_FROM_MEM for one cycle
// DONE   | broadcast STAGE_IDLE and pulse switch_done
module context_switch_scheduler #(
  parameter int NUM_CONTEXTS = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int STAGE_WIDTH = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = STAGE_WIDTH'(3),
  parameter logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM = STAGE_WIDTH'(4),
  localparam int CTX_WIDTH = (NUM_CONTEXTS > 2) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] upstream_stage,
  input  logic                   req_valid,
  input  logic                   req_local,
`ifdef CONTEXT_SWITCH_STATS_EN
  input  logic                   stats_clear,
  output logic [15:0]            stored_count,
  output logic [15:0]            local_count,
`endif
  output logic                   req_ready,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   local_context_switch,
  output logic [CTX_WIDTH-1:0]   context_id,
  output logic                   switch_done,
  output logic                   busy
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       settle_cnt, settle_cnt_nxt;
  logic                   accept;
  logic [STAGE_WIDTH-1:0] stage_nxt;
  logic [CTX_WIDTH-1:0]   ctx_nxt;
  logic                   local_nxt;
  logic                   ready_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      settle_cnt           <= '0;
      global_stage         <= STAGE_IDLE;
      local_context_switch <= 1'b0;
      context_id           <= '0;
      req_ready            <= 1'b0;
      switch_done          <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_nxt;
      settle_cnt           <= settle_cnt_nxt;
      global_stage         <= stage_nxt;
      local_context_switch <= local_nxt;
      context_id           <= ctx_nxt;
      req_ready            <= ready_nxt;
      switch_done          <= done_nxt;
      busy                 <= busy_nxt;
    end
  end

  // Outputs are registered from the next state so each stage appears in the cycle right after its transition.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    accept         = 1'b0;
    stage_nxt      = STAGE_IDLE;
    ctx_nxt        = context_id;
    local_nxt      = local_context_switch;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nxt      = S_SETTLE;
        settle_cnt_nxt = CNT_W'(SETTLE_EFF - 1);
        if (!local_context_switch) begin
          if (context_id == CTX_WIDTH'(NUM_CONTEXTS - 1)) ctx_nxt = '0;
          else ctx_nxt = context_id + CTX_WIDTH'(1);
        end
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_nxt = S_READ;
        else settle_cnt_nxt = settle_cnt - CNT_W'(1);
      end
      S_READ:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (accept) local_nxt = req_local;

    // Upstream is only forwarded once a full IDLE cycle has passed, so nothing sampled during DONE leaks out.
    case (state_nxt)
      S_WRITE: stage_nxt = STAGE_WRITE_TO_MEM;
      S_READ:  stage_nxt = STAGE_READ_FROM_MEM;
      S_IDLE:  stage_nxt = (state == S_IDLE) ? upstream_stage : STAGE_IDLE;
      default: stage_nxt = STAGE_IDLE;
    endcase

    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_DONE);
  end

`ifdef CONTEXT_SWITCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stored_count <= '0;
      local_count  <= '0;
    end else if (stats_clear) begin
      stored_count <= '0;
      local_count  <= '0;
    end else if (state == S_DONE) begin
      if (local_context_switch) begin
        if (local_count != 16'hFFFF) local_count <= local_count + 16'd1;
      end else begin
        if (stored_count != 16'hFFFF) stored_count <= stored_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_context_switch_scheduler.sv
// Scoreboard bench for context_switch_scheduler: a sequence-level model queues the expected per-cycle outputs,
// a monitor pops and compares them after every clock edge.
module tb_context_switch_scheduler;

  localparam int NUM_CTX = 2;
  localparam int S = 2;
  localparam int SW = 3;
  localparam int STG_IDLE = 0;
  localparam int STG_WRITE = 3;
  localparam int STG_READ = 4;

  typedef struct {
    int stage;
    int ready;
    int busy;
    int done;
    int ctx;
    int lcl;
    int sc;
    int lc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [SW-1:0] upstream_stage;
  logic          req_valid;
  logic          req_local;
  logic          req_ready;
  logic [SW-1:0] global_stage;
  logic          local_context_switch;
  logic [0:0]    context_id;
  logic          switch_done;
  logic          busy;
`ifdef CONTEXT_SWITCH_STATS_EN
  logic          stats_clear;
  logic [15:0]   stored_count;
  logic [15:0]   local_count;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t pend_q[$];
  exp_t cur, nxt, e;
  int   ctx_m, ctx_new, sc_m, lc_m;
  bit   model_en = 0;
  bit   held = 0;
  int   cyc = 0;
  int   last_done = -1;

  context_switch_scheduler #(
    .NUM_CONTEXTS(NUM_CTX),
    .SETTLE_CYCLES(S),
    .STAGE_WIDTH(SW),
    .STAGE_IDLE(3'd0),
    .STAGE_WRITE_TO_MEM(3'd3),
    .STAGE_READ_FROM_MEM(3'd4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .upstream_stage(upstream_stage),
    .req_valid(req_valid),
    .req_local(req_local),
`ifdef CONTEXT_SWITCH_STATS_EN
    .stats_clear(stats_clear),
    .stored_count(stored_count),
    .local_count(local_count),
`endif
    .req_ready(req_ready),
    .global_stage(global_stage),
    .local_context_switch(local_context_switch),
    .context_id(context_id),
    .switch_done(switch_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input int stg, input int rdy, input int bsy, input int dn, input int cx, input int lc);
    exp_t r;
    r = '{stg, rdy, bsy, dn, cx, lc, 0, 0};
    return r;
  endfunction

  task automatic model_reset();
    cur   = mk(STG_IDLE, 0, 0, 0, 0, 0);
    ctx_m = 0;
    sc_m  = 0;
    lc_m  = 0;
    exp_q.delete();
    pend_q.delete();
  endtask

  // Reference model: an accepted request expands into its whole timed output sequence.
  initial forever begin
    @(posedge clk);
    if (model_en) begin
`ifdef CONTEXT_SWITCH_STATS_EN
      if (stats_clear) begin
        sc_m = 0;
        lc_m = 0;
      end else if (cur.done == 1) begin
        if (cur.lcl == 1) lc_m = (lc_m < 65535) ? lc_m + 1 : lc_m;
        else sc_m = (sc_m < 65535) ? sc_m + 1 : sc_m;
      end
`endif
      if (cur.ready == 1 && req_valid) begin
        ctx_new = req_local ? ctx_m : (ctx_m + 1) % NUM_CTX;
        pend_q.push_back(mk(STG_WRITE, 0, 1, 0, ctx_m, int'(req_local)));
        for (int i = 0; i < S; i++) pend_q.push_back(mk(STG_IDLE, 0, 1, 0, ctx_new, int'(req_local)));
        pend_q.push_back(mk(STG_READ, 0, 1, 0, ctx_new, int'(req_local)));
        pend_q.push_back(mk(STG_IDLE, 0, 1, 1, ctx_new, int'(req_local)));
        pend_q.push_back(mk(STG_IDLE, 1, 0, 0, ctx_new, int'(req_local)));
        ctx_m = ctx_new;
      end
      if (pend_q.size() > 0) nxt = pend_q.pop_front();
      else nxt = mk(int'(upstream_stage), 1, 0, 0, ctx_m, cur.lcl);
      nxt.sc = sc_m;
      nxt.lc = lc_m;
      cur = nxt;
      exp_q.push_back(nxt);
    end
  end

  // Monitor: compare whatever the DUT presents after each edge with the oldest expectation.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("global_stage", 32'(global_stage), e.stage);
      check("req_ready", 32'(req_ready), e.ready);
      check("busy", 32'(busy), e.busy);
      check("switch_done", 32'(switch_done), e.done);
      check("context_id", 32'(context_id), e.ctx);
      check("local_context_switch", 32'(local_context_switch), e.lcl);
`ifdef CONTEXT_SWITCH_STATS_EN
      check("stored_count", 32'(stored_count), e.sc);
      check("local_count", 32'(local_count), e.lc);
`endif
      if (switch_done === 1'b1) begin
        if (held && last_done >= 0) check("b2b_period", cyc - last_done, S + 4);
        last_done = cyc;
      end
    end
  end

  task automatic do_switch(input bit l);
    req_valid = 1'b1;
    req_local = l;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S + 5) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      upstream_stage = SW'($urandom_range(0, 7));
      @(negedge clk);
    end
  endtask

  initial begin
    int k;
    reset = 1'b0;
    req_valid = 1'b0;
    req_local = 1'b0;
    upstream_stage = '0;
`ifdef CONTEXT_SWITCH_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_global_stage", 32'(global_stage), STG_IDLE);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_switch_done", 32'(switch_done), 0);
    check("rst_context_id", 32'(context_id), 0);
    check("rst_local", 32'(local_context_switch), 0);

    model_reset();
    reset = 1'b1;
    model_en = 1;
    upstream_stage = SW'(STG_IDLE);
    @(negedge clk);
    upstream_stage = SW'(6);
    @(negedge clk);
    upstream_stage = SW'(2);
    @(negedge clk);

    // Stored, stored (wrap), then local.
    do_switch(1'b0);
    do_switch(1'b0);
    do_switch(1'b1);
    idle_cycles(3);

    // Request held high with upstream churning throughout.
    held = 1;
    last_done = -1;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_local = 1'($urandom_range(0, 1));
      upstream_stage = SW'($urandom_range(0, 7));
      @(negedge clk);
    end
    req_valid = 1'b0;
    held = 0;
    idle_cycles(S + 6);

`ifdef CONTEXT_SWITCH_STATS_EN
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    repeat (3) do_switch(1'b0);
    repeat (2) do_switch(1'b1);
    req_valid = 1'b1;
    k = 0;
    while (!(cur.done == 1) && k < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
    end
    if (k >= 20) check("wait_done", 0, 1);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    idle_cycles(3);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_local = 1'($urandom_range(0, 1));
      upstream_stage = SW'($urandom_range(0, 7));
`ifdef CONTEXT_SWITCH_STATS_EN
      stats_clear = ($urandom_range(0, 15) == 0);
`endif
      @(negedge clk);
    end
    req_valid = 1'b0;
`ifdef CONTEXT_SWITCH_STATS_EN
    stats_clear = 1'b0;
`endif
    idle_cycles(S + 6);

    // Reset in the middle of SETTLE after a stored switch.
    req_valid = 1'b1;
    req_local = 1'b0;
    k = 0;
    while (!(cur.busy == 1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("wait_switch", 0, 1);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_en = 0;
    exp_q.delete();
    pend_q.delete();
    #1;
    check("midrst_global_stage", 32'(global_stage), STG_IDLE);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_context_id", 32'(context_id), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_switch_done", 32'(switch_done), 0);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    model_en = 1;
    idle_cycles(2);
    do_switch(1'b0);
    idle_cycles(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
